// File: rtl/axi_rrg_pkg.sv
// -----------------------------------------------------------------------------
// axi_rrg_pkg
// Shared types for the AXI read-response generator (axi_rd_resp_gen) and its
// beat FIFO (axi_rrg_fifo).
//   resp_t    : AXI RRESP encoding (EXOKAY is defined but never generated)
//   state_t   : burst FSM states
//   beat_resp : maps a memory-side beat error flag onto RRESP
// The beat-entry struct lives in axi_rd_resp_gen because its field widths
// follow that module's parameters, which a package cannot see.
// -----------------------------------------------------------------------------
package axi_rrg_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    ERRB  = 2'b10
  } state_t;

  // A beat error only affects the response of that beat.
  function automatic resp_t beat_resp(input logic err);
    resp_t r;
    if (err) begin
      r = SLVERR;
    end else begin
      r = OKAY;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rrg_fifo.sv
// -----------------------------------------------------------------------------
// axi_rrg_fifo
// Synchronous DEPTH x WIDTH FIFO holding R-channel beats.
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   push_i, push_data_i : write one entry (ignored while full)
//   pop_i          : retire the head entry (ignored while empty)
//   head_o         : head entry from storage registers, all-zero while empty
//   full_o, empty_o: occupancy flags derived from the entry count
// DEPTH must be a power of two (>=2) so pointers wrap naturally.
// -----------------------------------------------------------------------------
module axi_rrg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is zeroed while empty so idle R outputs read as zero.
  always_comb begin
    head_o = '0;
    if (empty_o) begin
      head_o = '0;
    end else begin
      head_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/axi_rd_resp_gen.sv
// -----------------------------------------------------------------------------
// axi_rd_resp_gen
// AXI slave read-response generator. Accepts one burst command at a time,
// pulls cmd_len+1 beats from the memory side (or fabricates DECERR beats for
// a failed decode), tags each beat with ID/RRESP/RLAST and queues it in a
// beat FIFO that feeds the AXI R channel with one cycle of latency.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : burst command handshake
//   cmd_id, cmd_len, cmd_decerr: burst ID, beats-1, decode-error flag
//   rd_valid/rd_ready          : memory beat handshake
//   rd_data, rd_err            : memory beat payload and slave-error flag
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY : AXI R channel
//   beat_count                 : R handshakes in the current burst
//                                (only when AXI_RRG_BEAT_CNT_EN is defined)
// Optional feature macro: AXI_RRG_BEAT_CNT_EN
// -----------------------------------------------------------------------------
module axi_rd_resp_gen
  import axi_rrg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_decerr,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
`ifdef AXI_RRG_BEAT_CNT_EN
  ,
  output logic [LEN_W:0]    beat_count
`endif
);

  localparam int BL_W = LEN_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    resp_t             resp;
    logic              last;
  } beat_t;

  localparam int ENTRY_W = $bits(beat_t);

  state_t          state_q, state_d;
  logic [BL_W-1:0] beats_left_q, beats_left_d;
  logic [ID_W-1:0] id_q, id_d;

  beat_t push_entry_s;
  beat_t head_s;
  logic  push_s;
  logic  pop_s;
  logic  last_s;
  logic  fifo_full_s;
  logic  fifo_empty_s;

  axi_rrg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign RVALID = ~fifo_empty_s;
  assign pop_s  = RVALID & RREADY;
  assign RID    = head_s.id;
  assign RDATA  = head_s.data;
  assign RRESP  = head_s.resp;
  assign RLAST  = head_s.last;

  // FSM state, remaining-beat counter and latched burst ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= BL_W'(0);
      id_q         <= ID_W'(0);
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      id_q         <= id_d;
    end
  end

  // Next-state, handshake and FIFO-push decode.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    id_d         = id_q;
    cmd_ready    = 1'b0;
    rd_ready     = 1'b0;
    push_s       = 1'b0;
    push_entry_s = '0;
    last_s       = (beats_left_q == BL_W'(1));
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          id_d = cmd_id;
          // Extra bit keeps len=max from wrapping to zero beats.
          beats_left_d = {1'b0, cmd_len} + BL_W'(1);
          if (cmd_decerr) begin
            state_d = ERRB;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        // No pass-through: a full FIFO blocks rd even if R pops this cycle.
        rd_ready = ~fifo_full_s;
        if (rd_valid && !fifo_full_s) begin
          push_s            = 1'b1;
          push_entry_s.id   = id_q;
          push_entry_s.data = rd_data;
          push_entry_s.resp = beat_resp(rd_err);
          push_entry_s.last = last_s;
          beats_left_d      = beats_left_q - BL_W'(1);
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      ERRB: begin
        // Decode failure: beats are fabricated, the memory side stays idle.
        if (!fifo_full_s) begin
          push_s            = 1'b1;
          push_entry_s.id   = id_q;
          push_entry_s.data = '0;
          push_entry_s.resp = DECERR;
          push_entry_s.last = last_s;
          beats_left_d      = beats_left_q - BL_W'(1);
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = ERRB;
          end
        end else begin
          state_d = ERRB;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXI_RRG_BEAT_CNT_EN
  logic [LEN_W:0] beat_count_q;

  // R handshakes seen in the burst currently draining; cleared by RLAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count_q <= (LEN_W+1)'(0);
    end else if (pop_s) begin
      if (RLAST) begin
        beat_count_q <= (LEN_W+1)'(0);
      end else begin
        beat_count_q <= beat_count_q + (LEN_W+1)'(1);
      end
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_axi_rd_resp_gen.sv
module tb_axi_rd_resp_gen;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic        cmd_decerr;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [5:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
`ifdef AXI_RRG_BEAT_CNT_EN
  logic [8:0]  beat_count;
`endif

  int errors = 0;
  int checks = 0;

  axi_rd_resp_gen #(
    .DATA_W (32),
    .ID_W   (6),
    .LEN_W  (8),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_len    (cmd_len),
    .cmd_decerr (cmd_decerr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .RID        (RID),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .RLAST      (RLAST),
    .RVALID     (RVALID),
    .RREADY     (RREADY)
`ifdef AXI_RRG_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [5:0] id, input logic [7:0] len, input logic decerr);
    cmd_valid  = 1'b1;
    cmd_id     = id;
    cmd_len    = len;
    cmd_decerr = decerr;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid  = 1'b0;
    cmd_decerr = 1'b0;
  endtask

  // Feeds nbeats memory beats (unless decerr) and checks every R beat.
  task automatic drain(input int nbeats, input logic [5:0] eid, input logic [31:0] base,
                       input int err_idx, input logic decerr);
    int pushed = 0;
    int got = 0;
    int cyc = 0;
    logic acc;
    while ((got < nbeats) && (cyc < 60)) begin
      rd_valid = (pushed < nbeats);
      rd_data  = base + 32'(pushed);
      rd_err   = (pushed == err_idx);
      if (decerr) chk("decerr_rd_ready", rd_ready, 1'b0);
      if (RVALID && RREADY) begin
        chk("drain_rid", RID, eid);
        chk("drain_rdata", RDATA, decerr ? 32'h0 : base + 32'(got));
        chk("drain_rresp", RRESP, decerr ? 2'b11 : ((got == err_idx) ? 2'b10 : 2'b00));
        chk("drain_rlast", RLAST, (got == nbeats - 1));
        got++;
      end
      acc = rd_valid && rd_ready;
      step();
      if (acc) pushed++;
      cyc++;
    end
    rd_valid = 1'b0;
    rd_err   = 1'b0;
    chk("drain_beats", got, nbeats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   got;
    int   cyc;
    logic acc;

    reset = 1'b1; cmd_valid = 1'b0; cmd_id = 6'h0; cmd_len = 8'h0; cmd_decerr = 1'b0;
    rd_valid = 1'b0; rd_data = 32'h0; rd_err = 1'b0; RREADY = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rlast", RLAST, 1'b0);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_rid", RID, 6'h0);
    chk("rst_rdata", RDATA, 32'h0);
`ifdef AXI_RRG_BEAT_CNT_EN
    chk("rst_beat_count", beat_count, 9'd0);
`endif

    // Test 1: id 0x15, len 3, 1 beat/cycle, RREADY=1
    RREADY = 1'b1;
    send_cmd(6'h15, 8'd3, 1'b0);
    chk("t1_cmd_ready_busy", cmd_ready, 1'b0);
    chk("t1_rd_ready", rd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1;
      rd_data  = 32'hA000_0000 + 32'(i);
      if (i == 0) chk("t1_rvalid_before_push", RVALID, 1'b0);
      step();
      chk("t1_rvalid", RVALID, 1'b1);
      chk("t1_rdata", RDATA, 32'hA000_0000 + 32'(i));
      chk("t1_rid", RID, 6'h15);
      chk("t1_rresp", RRESP, 2'b00);
      chk("t1_rlast", RLAST, (i == 3));
`ifdef AXI_RRG_BEAT_CNT_EN
      if (i == 1) chk("t1_beat_count_mid", beat_count, 9'd1);
`endif
    end
    rd_valid = 1'b0;
    chk("t1_rd_ready_done", rd_ready, 1'b0);
    chk("t1_cmd_ready_done", cmd_ready, 1'b1);
    step();
    chk("t1_rvalid_drained", RVALID, 1'b0);
`ifdef AXI_RRG_BEAT_CNT_EN
    chk("t1_beat_count_end", beat_count, 9'd0);
`endif

    // Test 2: len 7 with RREADY stalled for 10 cycles
    RREADY = 1'b0;
    send_cmd(6'h2A, 8'd7, 1'b0);
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      rd_valid = 1'b1;
      rd_data  = 32'hB000_0000 + 32'(idx);
      acc = rd_ready;
      step();
      if (acc) idx++;
      chk("t2_hold_rdata", RDATA, 32'hB000_0000);
    end
    chk("t2_accepted", idx, 4);
    chk("t2_rd_ready_full", rd_ready, 1'b0);
    chk("t2_rvalid", RVALID, 1'b1);
    chk("t2_hold_rid", RID, 6'h2A);
    chk("t2_hold_rlast", RLAST, 1'b0);
    RREADY = 1'b1;
    got = 0;
    cyc = 0;
    while ((got < 8) && (cyc < 40)) begin
      rd_valid = (idx < 8);
      rd_data  = 32'hB000_0000 + 32'(idx);
      acc = rd_valid && rd_ready;
      if (RVALID) begin
        chk("t2_rdata", RDATA, 32'hB000_0000 + 32'(got));
        chk("t2_rid", RID, 6'h2A);
        chk("t2_rlast", RLAST, (got == 7));
        got++;
      end
      step();
      if (acc) idx++;
      cyc++;
    end
    rd_valid = 1'b0;
    chk("t2_total_beats", got, 8);
    chk("t2_rvalid_drained", RVALID, 1'b0);
`ifdef AXI_RRG_BEAT_CNT_EN
    chk("t2_beat_count_end", beat_count, 9'd0);
`endif

    // Test 3: decode error, len 2
    send_cmd(6'h07, 8'd2, 1'b1);
    drain(3, 6'h07, 32'hDEAD_0000, -1, 1'b1);

    // Test 4: len 3 with rd_err on beat 2 only
    send_cmd(6'h33, 8'd3, 1'b0);
    drain(4, 6'h33, 32'hC000_0000, 1, 1'b0);
    step();

    // Test 5: back-to-back commands before the first burst drains
    RREADY = 1'b0;
    send_cmd(6'h01, 8'd1, 1'b0);
    rd_valid = 1'b1;
    rd_data  = 32'h0000_00C0;
    step();
    rd_data  = 32'h0000_00C1;
    step();
    rd_valid = 1'b0;
    chk("t5_rvalid", RVALID, 1'b1);
    chk("t5_rid_first", RID, 6'h01);
    send_cmd(6'h02, 8'd0, 1'b0);
    rd_valid = 1'b1;
    rd_data  = 32'h0000_00D0;
    step();
    rd_valid = 1'b0;
    chk("t5_rid_held", RID, 6'h01);
    chk("t5_rdata_held", RDATA, 32'h0000_00C0);
    RREADY = 1'b1;
    chk("t5_b0_rid", RID, 6'h01);
    chk("t5_b0_rdata", RDATA, 32'h0000_00C0);
    chk("t5_b0_rlast", RLAST, 1'b0);
    step();
    chk("t5_b1_rid", RID, 6'h01);
    chk("t5_b1_rdata", RDATA, 32'h0000_00C1);
    chk("t5_b1_rlast", RLAST, 1'b1);
    step();
    chk("t5_b2_rvalid", RVALID, 1'b1);
    chk("t5_b2_rid", RID, 6'h02);
    chk("t5_b2_rdata", RDATA, 32'h0000_00D0);
    chk("t5_b2_rlast", RLAST, 1'b1);
    step();
    chk("t5_drained", RVALID, 1'b0);

    // Test 6: reset in the middle of a burst
    RREADY = 1'b0;
    send_cmd(6'h09, 8'd3, 1'b0);
    rd_valid = 1'b1;
    rd_data  = 32'h0000_0E00;
    step();
    rd_data  = 32'h0000_0E01;
    RREADY   = 1'b1;
    step();
    rd_valid = 1'b0;
    RREADY   = 1'b0;
    chk("t6_rvalid_pre", RVALID, 1'b1);
    chk("t6_rdata_pre", RDATA, 32'h0000_0E01);
`ifdef AXI_RRG_BEAT_CNT_EN
    chk("t6_beat_count_pre", beat_count, 9'd1);
`endif
    reset = 1'b1;
    step();
    chk("t6_rvalid_rst", RVALID, 1'b0);
    chk("t6_cmd_ready_rst", cmd_ready, 1'b1);
    chk("t6_rd_ready_rst", rd_ready, 1'b0);
    chk("t6_rid_rst", RID, 6'h0);
    chk("t6_rdata_rst", RDATA, 32'h0);
    chk("t6_rlast_rst", RLAST, 1'b0);
`ifdef AXI_RRG_BEAT_CNT_EN
    chk("t6_beat_count_rst", beat_count, 9'd0);
`endif
    reset = 1'b0;
    step();
    chk("t6_rvalid_after", RVALID, 1'b0);
    chk("t6_cmd_ready_after", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
